mandel_view_regs: RTL

//  AXI-Lite slave holding Mandelbrot view parameters (centre, zoom, iteration cap) for the pixel generator.

---
 rtl/mandel_view_regs.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mandel_view_regs.sv
// mandel_view_regs: AXI-Lite shadow/active view registers for the Mandelbrot pixel path.
// Software stages a shadow set; a commit copies it to the active outputs at the next frame_start.
module mandel_view_regs #(
   parameter int WORD_LENGTH = 64,
   parameter int FRAC        = 60,
   parameter int AXI_ADDR_W  = 8
) (
   input  logic                   s_axi_lite_aclk,
   input  logic                   periph_resetn,
   input  logic [AXI_ADDR_W-1:0]  s_axi_lite_awaddr,
   input  logic                   s_axi_lite_awvalid,
   output logic                   s_axi_lite_awready,
   input  logic [31:0]            s_axi_lite_wdata,
   input  logic                   s_axi_lite_wvalid,
   output logic                   s_axi_lite_wready,
   output logic [1:0]             s_axi_lite_bresp,
   output logic                   s_axi_lite_bvalid,
   input  logic                   s_axi_lite_bready,
   input  logic [AXI_ADDR_W-1:0]  s_axi_lite_araddr,
   input  logic                   s_axi_lite_arvalid,
   output logic                   s_axi_lite_arready,
   output logic [31:0]            s_axi_lite_rdata,
   output logic [1:0]             s_axi_lite_rresp,
   output logic                   s_axi_lite_rvalid,
   input  logic                   s_axi_lite_rready,
   input  logic                   frame_start,
   output logic [WORD_LENGTH-1:0] real_center,
   output logic [WORD_LENGTH-1:0] imag_center,
   output logic [WORD_LENGTH-1:0] zoom,
   output logic [15:0]            max_iter,
   output logic                   params_updated
);
   localparam logic [WORD_LENGTH-1:0] RST_RE = WORD_LENGTH'(0) - (WORD_LENGTH'(3) << (FRAC - 2));
   localparam logic [WORD_LENGTH-1:0] RST_ZM = WORD_LENGTH'(1024);
   localparam logic [15:0]            RST_IT = 16'd255;
   typedef enum logic [2:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_DO, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;
   wstate_t ws;
   rstate_t rs;
   logic [5:0] wa, ra;
   logic [31:0] wd, rd_word;
   logic [WORD_LENGTH-1:0] sh_re, sh_im, sh_zm;
   logic [15:0] sh_it, frame_cnt;
   logic pending;
   logic unused_addr_bits;
   assign unused_addr_bits = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};
   // word address = byte address [7:2]; only indices 0..8 of the lowest 64 bytes exist
   function automatic logic addr_ok(input logic [5:0] a);
      return a[5:4] == 2'b00 && a[3:0] <= 4'd8;
   endfunction
   always_ff @(posedge s_axi_lite_aclk or negedge periph_resetn)
      if (!periph_resetn) begin
         ws <= W_IDLE;
         s_axi_lite_awready <= 1'b1;
         s_axi_lite_wready <= 1'b1;
         s_axi_lite_bvalid <= 1'b0;
         s_axi_lite_bresp <= 2'b00;
         wa <= '0;
         wd <= '0;
         sh_re <= RST_RE;
         sh_im <= '0;
         sh_zm <= RST_ZM;
         sh_it <= RST_IT;
         pending <= 1'b0;
      end else begin
         if (frame_start && pending) pending <= 1'b0;
         case (ws)
            W_IDLE: begin
               if (s_axi_lite_awvalid) wa <= s_axi_lite_awaddr[7:2];
               if (s_axi_lite_wvalid) wd <= s_axi_lite_wdata;
               if (s_axi_lite_awvalid && s_axi_lite_wvalid) begin
                  ws <= W_DO;
                  s_axi_lite_awready <= 1'b0;
                  s_axi_lite_wready <= 1'b0;
               end else if (s_axi_lite_awvalid) begin
                  ws <= W_WAIT_W;
                  s_axi_lite_awready <= 1'b0;
               end else if (s_axi_lite_wvalid) begin
                  ws <= W_WAIT_AW;
                  s_axi_lite_wready <= 1'b0;
               end
            end
            W_WAIT_W: if (s_axi_lite_wvalid) begin
               wd <= s_axi_lite_wdata;
               s_axi_lite_wready <= 1'b0;
               ws <= W_DO;
            end
            W_WAIT_AW: if (s_axi_lite_awvalid) begin
               wa <= s_axi_lite_awaddr[7:2];
               s_axi_lite_awready <= 1'b0;
               ws <= W_DO;
            end
            W_DO: begin
               s_axi_lite_bvalid <= 1'b1;
               s_axi_lite_bresp <= addr_ok(wa) ? 2'b00 : 2'b10;
               ws <= W_RESP;
               // a commit landing with frame_start is kept for the following frame
               if (addr_ok(wa))
                  case (wa[3:0])
                     4'd0: if (wd[0]) pending <= 1'b1;
                     4'd2: sh_re[31:0] <= wd;
                     4'd3: sh_re[63:32] <= wd;
                     4'd4: sh_im[31:0] <= wd;
                     4'd5: sh_im[63:32] <= wd;
                     4'd6: sh_zm[31:0] <= wd;
                     4'd7: sh_zm[63:32] <= wd;
                     4'd8: sh_it <= wd[15:0];
                     default: ;
                  endcase
            end
            W_RESP: if (s_axi_lite_bready) begin
               s_axi_lite_bvalid <= 1'b0;
               s_axi_lite_awready <= 1'b1;
               s_axi_lite_wready <= 1'b1;
               ws <= W_IDLE;
            end
            default: ws <= W_IDLE;
         endcase
      end
   always_comb begin
      rd_word = '0;
      if (addr_ok(ra))
         case (ra[3:0])
            4'd1: rd_word = {frame_cnt, 15'd0, pending};
            4'd2: rd_word = sh_re[31:0];
            4'd3: rd_word = sh_re[63:32];
            4'd4: rd_word = sh_im[31:0];
            4'd5: rd_word = sh_im[63:32];
            4'd6: rd_word = sh_zm[31:0];
            4'd7: rd_word = sh_zm[63:32];
            4'd8: rd_word = {16'd0, sh_it};
            default: rd_word = '0;
         endcase
   end
   always_ff @(posedge s_axi_lite_aclk or negedge periph_resetn)
      if (!periph_resetn) begin
         rs <= R_IDLE;
         ra <= '0;
         s_axi_lite_arready <= 1'b1;
         s_axi_lite_rvalid <= 1'b0;
         s_axi_lite_rdata <= '0;
         s_axi_lite_rresp <= 2'b00;
      end else
         case (rs)
            R_IDLE: if (s_axi_lite_arvalid) begin
               ra <= s_axi_lite_araddr[7:2];
               s_axi_lite_arready <= 1'b0;
               rs <= R_FETCH;
            end
            R_FETCH: begin
               s_axi_lite_rdata <= rd_word;
               s_axi_lite_rresp <= addr_ok(ra) ? 2'b00 : 2'b10;
               s_axi_lite_rvalid <= 1'b1;
               rs <= R_DATA;
            end
            R_DATA: if (s_axi_lite_rready) begin
               s_axi_lite_rvalid <= 1'b0;
               s_axi_lite_arready <= 1'b1;
               rs <= R_IDLE;
            end
            default: rs <= R_IDLE;
         endcase
   always_ff @(posedge s_axi_lite_aclk or negedge periph_resetn)
      if (!periph_resetn) begin
         real_center <= RST_RE;
         imag_center <= '0;
         zoom <= RST_ZM;
         max_iter <= RST_IT;
         frame_cnt <= '0;
         params_updated <= 1'b0;
      end else begin
         params_updated <= frame_start && pending;
         if (frame_start) frame_cnt <= frame_cnt + 16'd1;
         if (frame_start && pending) begin
            real_center <= sh_re;
            imag_center <= sh_im;
            zoom <= sh_zm;
            max_iter <= sh_it;
         end
      end
endmodule
